// File: rtl/enc_pkg.sv
// Shared constants and types for the RV32I instruction encoder.
// Formats are one-hot; LI expands into LUI/ADDI beats.
package enc_pkg;

  localparam int FMT_R = 0;
  localparam int FMT_I = 1;
  localparam int FMT_S = 2;
  localparam int FMT_B = 3;
  localparam int FMT_U = 4;
  localparam int FMT_J = 5;

  localparam logic [1:0] OP_RAW = 2'b00;
  localparam logic [1:0] OP_LI  = 2'b01;

  localparam logic [6:0] OPC_OPIMM = 7'h13;
  localparam logic [6:0] OPC_LUI   = 7'h37;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EMIT1,
    ST_EMIT2_PEND
  } state_t;

  typedef struct packed {
    logic [5:0]  fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } pack_req_t;

endpackage

// File: rtl/inst_encoder_if.sv
// Request and instruction-beat streams of the encoder.
// slave is the encoder's view, master the requester/sink view.
interface inst_encoder_if;

  logic        i_valid;
  logic        o_ready;
  logic [1:0]  i_op;
  logic [5:0]  i_format;
  logic [6:0]  i_opcode;
  logic [2:0]  i_funct3;
  logic [6:0]  i_funct7;
  logic [4:0]  i_rd;
  logic [4:0]  i_rs1;
  logic [4:0]  i_rs2;
  logic [31:0] i_imm;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_inst;
  logic        o_err;
  logic        o_last;

  modport slave (
    input  i_valid, i_op, i_format,
    input  i_opcode, i_funct3, i_funct7,
    input  i_rd, i_rs1, i_rs2, i_imm,
    input  i_ready,
    output o_ready, o_valid, o_inst,
    output o_err, o_last
  );

  modport master (
    output i_valid, i_op, i_format,
    output i_opcode, i_funct3, i_funct7,
    output i_rd, i_rs1, i_rs2, i_imm,
    output i_ready,
    input  o_ready, o_valid, o_inst,
    input  o_err, o_last
  );

endinterface

// File: rtl/imm_pack.sv
// Combinational field/immediate packer with range check.
// Unrepresentable immediates or bad formats yield a NOP.
module imm_pack
  import enc_pkg::*;
(
  input  pack_req_t   req,
  output logic [31:0] inst,
  output logic        err
);

  logic        onehot;
  logic        bad;
  logic [31:0] raw;
  logic [31:0] m;

  // a range fits when the high bits are all sign copies
  always_comb begin
    raw    = '0;
    bad    = 1'b0;
    m      = req.imm;
    onehot = (req.fmt != '0) &&
             ((req.fmt & (req.fmt - 6'd1)) == '0);
    if (!onehot) begin
      bad = 1'b1;
    end else begin
      unique case (1'b1)
        req.fmt[FMT_R]: begin
          raw = {req.funct7, req.rs2, req.rs1,
                 req.funct3, req.rd, req.opcode};
        end
        req.fmt[FMT_I]: begin
          raw = {m[11:0], req.rs1, req.funct3,
                 req.rd, req.opcode};
          bad = (&m[31:11]) != (|m[31:11]);
        end
        req.fmt[FMT_S]: begin
          raw = {m[11:5], req.rs2, req.rs1,
                 req.funct3, m[4:0], req.opcode};
          bad = (&m[31:11]) != (|m[31:11]);
        end
        req.fmt[FMT_B]: begin
          raw = {m[12], m[10:5], req.rs2, req.rs1,
                 req.funct3, m[4:1], m[11],
                 req.opcode};
          bad = m[0] ||
                ((&m[31:12]) != (|m[31:12]));
        end
        req.fmt[FMT_U]: begin
          raw = {m[31:12], req.rd, req.opcode};
          bad = m[11:0] != '0;
        end
        req.fmt[FMT_J]: begin
          raw = {m[20], m[10:1], m[11], m[19:12],
                 req.rd, req.opcode};
          bad = m[0] ||
                ((&m[31:20]) != (|m[31:20]));
        end
        default: bad = 1'b1;
      endcase
    end
    inst = bad ? INST_NOP : raw;
    err  = bad;
  end

endmodule

// File: rtl/inst_encoder.sv
// RV32I instruction encoder: RAW packing and LI expansion.
// One packer serves both the request and the pending ADDI.
module inst_encoder
  import enc_pkg::*;
(
  input  logic           i_clk,
  input  logic           i_rst,
  inst_encoder_if.slave  bus
);

  state_t      state;
  logic [4:0]  pend_rd;
  logic [11:0] pend_lo;

  logic        accept;
  logic        hs;
  logic        is_li;
  logic        li_small;
  logic        li_zero;
  logic        lo_zero;
  logic [31:0] li_hi;

  pack_req_t   pk;
  logic [31:0] pk_inst;
  logic        pk_err;

  logic [31:0] nxt_inst;
  logic        nxt_err;
  logic        nxt_last;

  assign bus.o_ready = !i_rst &&
    (state == ST_IDLE ||
     (state == ST_EMIT1 && bus.i_ready));

  assign accept = bus.i_valid && bus.o_ready;
  assign hs     = bus.o_valid && bus.i_ready;

  always_comb begin
    is_li    = bus.i_op == OP_LI;
    li_small = (&bus.i_imm[31:11]) ==
               (|bus.i_imm[31:11]);
    li_hi    = bus.i_imm + 32'h0000_0800;
    lo_zero  = bus.i_imm[11:0] == '0;
    li_zero  = bus.i_rd == '0;

    pk.fmt    = bus.i_format;
    pk.opcode = bus.i_opcode;
    pk.funct3 = bus.i_funct3;
    pk.funct7 = bus.i_funct7;
    pk.rd     = bus.i_rd;
    pk.rs1    = bus.i_rs1;
    pk.rs2    = bus.i_rs2;
    pk.imm    = bus.i_imm;

    // no accept can coincide with a pending ADDI
    if (state == ST_EMIT2_PEND) begin
      pk.fmt        = '0;
      pk.fmt[FMT_I] = 1'b1;
      pk.opcode     = OPC_OPIMM;
      pk.funct3     = '0;
      pk.funct7     = '0;
      pk.rd         = pend_rd;
      pk.rs1        = pend_rd;
      pk.rs2        = '0;
      pk.imm        = {{20{pend_lo[11]}}, pend_lo};
    end else if (is_li) begin
      pk.fmt    = '0;
      pk.funct3 = '0;
      pk.funct7 = '0;
      pk.rs1    = '0;
      pk.rs2    = '0;
      if (li_small) begin
        pk.fmt[FMT_I] = 1'b1;
        pk.opcode     = OPC_OPIMM;
      end else begin
        pk.fmt[FMT_U] = 1'b1;
        pk.opcode     = OPC_LUI;
        pk.imm        = {li_hi[31:12], 12'h000};
      end
    end

    nxt_inst = (is_li && li_zero) ? INST_NOP : pk_inst;
    nxt_err  = !is_li && pk_err;
    nxt_last = !is_li || li_zero ||
               li_small || lo_zero;
  end

  imm_pack u_pack (
    .req  (pk),
    .inst (pk_inst),
    .err  (pk_err)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      bus.o_valid <= 1'b0;
      bus.o_inst  <= '0;
      bus.o_err   <= 1'b0;
      bus.o_last  <= 1'b0;
      pend_rd     <= '0;
      pend_lo     <= '0;
    end else begin
      case (state)
        ST_EMIT2_PEND: begin
          if (hs) begin
            bus.o_inst <= pk_inst;
            bus.o_err  <= 1'b0;
            bus.o_last <= 1'b1;
            state      <= ST_EMIT1;
          end
        end
        default: begin
          if (accept) begin
            bus.o_valid <= 1'b1;
            bus.o_inst  <= nxt_inst;
            bus.o_err   <= nxt_err;
            bus.o_last  <= nxt_last;
            pend_rd     <= bus.i_rd;
            pend_lo     <= bus.i_imm[11:0];
            state       <= nxt_last ? ST_EMIT1
                                    : ST_EMIT2_PEND;
          end else if (hs) begin
            bus.o_valid <= 1'b0;
            state       <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder with immediate assertions.
// Expected words are hand-encoded RV32I instructions.
module tb_inst_encoder;
  import enc_pkg::*;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  inst_encoder_if bus();

  inst_encoder dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // called at a negedge; returns at the negedge after accept
  task automatic send(input logic [1:0]  op,
                      input logic [5:0]  fmt,
                      input logic [6:0]  opc,
                      input logic [2:0]  f3,
                      input logic [6:0]  f7,
                      input logic [4:0]  rd,
                      input logic [4:0]  rs1,
                      input logic [4:0]  rs2,
                      input logic [31:0] imm);
    int n;
    bus.i_op     = op;
    bus.i_format = fmt;
    bus.i_opcode = opc;
    bus.i_funct3 = f3;
    bus.i_funct7 = f7;
    bus.i_rd     = rd;
    bus.i_rs1    = rs1;
    bus.i_rs2    = rs2;
    bus.i_imm    = imm;
    bus.i_valid  = 1'b1;
    #1;
    n = 0;
    while (!bus.o_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("accept_ready", {31'd0, bus.o_ready}, 32'd1);
    @(posedge clk);
    #1 bus.i_valid = 1'b0;
    @(negedge clk);
  endtask

  // checks the held beat, then lets it handshake
  task automatic beat(input string tag,
                      input logic [31:0] inst,
                      input logic err,
                      input logic last);
    chk({tag, "_valid"}, {31'd0, bus.o_valid}, 32'd1);
    chk({tag, "_inst"}, bus.o_inst, inst);
    chk({tag, "_err"}, {31'd0, bus.o_err}, {31'd0, err});
    chk({tag, "_last"}, {31'd0, bus.o_last}, {31'd0, last});
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    compared     = 0;
    mismatched   = 0;
    rst          = 1'b1;
    bus.i_valid  = 1'b0;
    bus.i_ready  = 1'b0;
    bus.i_op     = '0;
    bus.i_format = '0;
    bus.i_opcode = '0;
    bus.i_funct3 = '0;
    bus.i_funct7 = '0;
    bus.i_rd     = '0;
    bus.i_rs1    = '0;
    bus.i_rs2    = '0;
    bus.i_imm    = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("rst_inst", bus.o_inst, 32'd0);
    chk("rst_err", {31'd0, bus.o_err}, 32'd0);
    chk("rst_last", {31'd0, bus.o_last}, 32'd0);
    chk("rst_ready", {31'd0, bus.o_ready}, 32'd0);
    rst = 1'b0;
    bus.i_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, bus.o_ready}, 32'd1);

    // RAW formats
    send(OP_RAW, 6'b000010, 7'h13, 3'd0, 7'd0,
         5'd5, 5'd6, 5'd0, 32'hFFFF_FFFF);
    beat("raw_i", 32'hFFF3_0293, 1'b0, 1'b1);
    send(OP_RAW, 6'b001000, 7'h63, 3'd0, 7'd0,
         5'd0, 5'd1, 5'd2, 32'd8);
    beat("raw_b", 32'h0020_8463, 1'b0, 1'b1);
    send(OP_RAW, 6'b001000, 7'h63, 3'd0, 7'd0,
         5'd0, 5'd1, 5'd2, 32'd5);
    beat("raw_b_odd", INST_NOP, 1'b1, 1'b1);
    send(OP_RAW, 6'b000100, 7'h23, 3'd2, 7'd0,
         5'd0, 5'd2, 5'd3, 32'hFFFF_FFFC);
    beat("raw_s", 32'hFE31_2E23, 1'b0, 1'b1);
    send(OP_RAW, 6'b000001, 7'h33, 3'd0, 7'd0,
         5'd1, 5'd2, 5'd3, 32'hDEAD_BEEF);
    beat("raw_r", 32'h0031_00B3, 1'b0, 1'b1);
    send(OP_RAW, 6'b010000, 7'h37, 3'd0, 7'd0,
         5'd1, 5'd0, 5'd0, 32'h1234_5000);
    beat("raw_u", 32'h1234_50B7, 1'b0, 1'b1);
    send(OP_RAW, 6'b010000, 7'h37, 3'd0, 7'd0,
         5'd1, 5'd0, 5'd0, 32'h1234_5001);
    beat("raw_u_low", INST_NOP, 1'b1, 1'b1);
    send(OP_RAW, 6'b100000, 7'h6F, 3'd0, 7'd0,
         5'd1, 5'd0, 5'd0, 32'd2048);
    beat("raw_j", 32'h0010_00EF, 1'b0, 1'b1);
    send(OP_RAW, 6'b100000, 7'h6F, 3'd0, 7'd0,
         5'd1, 5'd0, 5'd0, 32'd1048576);
    beat("raw_j_range", INST_NOP, 1'b1, 1'b1);
    send(OP_RAW, 6'b000110, 7'h13, 3'd0, 7'd0,
         5'd5, 5'd6, 5'd0, 32'd1);
    beat("raw_multi", INST_NOP, 1'b1, 1'b1);
    send(2'b11, 6'b000000, 7'h13, 3'd0, 7'd0,
         5'd5, 5'd6, 5'd0, 32'd1);
    beat("raw_nofmt", INST_NOP, 1'b1, 1'b1);

    // LI two-beat with backpressure on the LUI
    bus.i_ready = 1'b0;
    send(OP_LI, 6'b0, 7'h0, 3'd0, 7'd0,
         5'd10, 5'd0, 5'd0, 32'h1234_5FFF);
    bus.i_rd  = 5'd3;
    bus.i_imm = 32'd0;
    chk("li_lui_inst", bus.o_inst, 32'h1234_6537);
    chk("li_lui_last", {31'd0, bus.o_last}, 32'd0);
    chk("li_lui_ready", {31'd0, bus.o_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("li_hold_valid", {31'd0, bus.o_valid}, 32'd1);
      chk("li_hold_inst", bus.o_inst, 32'h1234_6537);
      chk("li_hold_ready", {31'd0, bus.o_ready}, 32'd0);
    end
    bus.i_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    beat("li_addi", 32'hFFF5_0513, 1'b0, 1'b1);
    chk("li_done", {31'd0, bus.o_valid}, 32'd0);

    send(OP_LI, 6'b0, 7'h0, 3'd0, 7'd0,
         5'd1, 5'd0, 5'd0, 32'h0000_1000);
    beat("li_lui_only", 32'h0000_10B7, 1'b0, 1'b1);
    send(OP_LI, 6'b0, 7'h0, 3'd0, 7'd0,
         5'd1, 5'd0, 5'd0, 32'd100);
    beat("li_small", 32'h0640_0093, 1'b0, 1'b1);
    send(OP_LI, 6'b0, 7'h0, 3'd0, 7'd0,
         5'd0, 5'd0, 5'd0, 32'h1234_5678);
    beat("li_x0", INST_NOP, 1'b0, 1'b1);
    chk("idle_valid", {31'd0, bus.o_valid}, 32'd0);

    // back-to-back RAW I, one per cycle
    bus.i_op     = OP_RAW;
    bus.i_format = 6'b000010;
    bus.i_opcode = 7'h13;
    bus.i_funct3 = 3'd0;
    bus.i_rd     = 5'd5;
    bus.i_rs1    = 5'd6;
    bus.i_imm    = 32'd1;
    bus.i_valid  = 1'b1;
    @(posedge clk);
    #1 bus.i_imm = 32'd2047;
    @(negedge clk);
    chk("b2b_a", bus.o_inst, 32'h0013_0293);
    chk("b2b_a_ready", {31'd0, bus.o_ready}, 32'd1);
    @(posedge clk);
    #1 bus.i_imm = 32'hFFFF_F800;
    @(negedge clk);
    chk("b2b_b", bus.o_inst, 32'h7FF3_0293);
    chk("b2b_b_ready", {31'd0, bus.o_ready}, 32'd1);
    @(posedge clk);
    #1 bus.i_imm = 32'd2048;
    @(negedge clk);
    chk("b2b_c", bus.o_inst, 32'h8003_0293);
    chk("b2b_c_ready", {31'd0, bus.o_ready}, 32'd1);
    @(posedge clk);
    #1 bus.i_valid = 1'b0;
    @(negedge clk);
    beat("b2b_d_range", INST_NOP, 1'b1, 1'b1);
    chk("b2b_idle", {31'd0, bus.o_valid}, 32'd0);

    // reset while the LUI is held
    bus.i_ready = 1'b0;
    send(OP_LI, 6'b0, 7'h0, 3'd0, 7'd0,
         5'd10, 5'd0, 5'd0, 32'h1234_5FFF);
    chk("rl_lui", bus.o_inst, 32'h1234_6537);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rl_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("rl_ready", {31'd0, bus.o_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.i_ready = 1'b1;
    #1;
    chk("rl_ready_rel", {31'd0, bus.o_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rl_no_addi", {31'd0, bus.o_valid}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
